// File: rtl/imem_pkg.sv
// ---------------------------------------------------------------------------
// imem_pkg
// Shared types and helpers for the loadable instruction memory (imem_fetch).
//   imem_state_e      : CLEAR / RUN / LOAD sequencer states
//   NOP_WORD          : value written by the clear sequencer and returned on
//                       faulted fetches
//   fetch_fault_check : misaligned / out-of-range test for a fetch address
// ---------------------------------------------------------------------------
package imem_pkg;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        RUN   = 2'd1,
        LOAD  = 2'd2
    } imem_state_e;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    // A fetch faults when a byte address is not word aligned, or when any pc
    // bit above the word-index field is set (the address lies past the array).
    function automatic logic fetch_fault_check(
        input logic [31:0] pc,
        input int unsigned addr_width,
        input logic        byte_addr
    );
        int unsigned field_top;
        logic        misaligned;
        logic        out_of_range;
        field_top    = byte_addr ? addr_width + 2 : addr_width;
        misaligned   = byte_addr && (pc[1:0] != 2'b00);
        out_of_range = (field_top < 32) ? ((pc >> field_top) != 32'd0) : 1'b0;
        return misaligned || out_of_range;
    endfunction

endpackage

// File: rtl/imem_ram.sv
// ---------------------------------------------------------------------------
// imem_ram
// DEPTH x WIDTH storage array with one write port and one synchronous read
// port. The array itself is not reset; only the read-data register is, so the
// fetch outputs come up as zero.
// Ports:
//   i_clk, i_rst_n     clock, synchronous active-low reset (read register)
//   i_we/i_waddr/i_wdata   write port
//   i_re/i_raddr       read enable and address; o_rdata holds when i_re=0
//   o_rdata            registered read data
// ---------------------------------------------------------------------------
module imem_ram #(
    parameter int ADDR_WIDTH = 6,
    parameter int WIDTH      = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [WIDTH-1:0]      i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [WIDTH-1:0]      o_rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Write port: no reset, contents are initialised by the clear sequencer.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read port: the register holds its value while i_re is low, which is
    // what lets the fetch stage freeze its output during a stall.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/imem_fetch.sv
// ---------------------------------------------------------------------------
// imem_fetch
// Synchronous-read, run-time loadable instruction memory sitting between the
// PC register and the IF/ID register. After every reset the array is cleared
// to NOP_WORD (DEPTH cycles), then fetches are served with one cycle latency.
// Optional feature macro: IMEM_PARITY_EN adds a stored even-parity bit per
// word and drives o_parity_err; without it o_parity_err is tied to 0.
// Ports:
//   i_clk, i_rst_n                 clock, synchronous active-low reset
//   i_fetch_req/_pc/_stall/_flush  fetch request side
//   o_instr, o_instr_valid         fetched word and its valid
//   o_fetch_fault, o_parity_err    status, qualified by o_instr_valid
//   i_load_start/_done/_we/_addr/_data   program-load port
//   o_ready                        high while the sequencer is in RUN
// ---------------------------------------------------------------------------
module imem_fetch
    import imem_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_ADDR  = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_fetch_req,
    input  logic [31:0]           i_fetch_pc,
    input  logic                  i_fetch_stall,
    input  logic                  i_fetch_flush,
    output logic [DATA_WIDTH-1:0] o_instr,
    output logic                  o_instr_valid,
    output logic                  o_fetch_fault,
    output logic                  o_parity_err,
    input  logic                  i_load_start,
    input  logic                  i_load_done,
    input  logic                  i_load_we,
    input  logic [ADDR_WIDTH-1:0] i_load_addr,
    input  logic [DATA_WIDTH-1:0] i_load_data,
    output logic                  o_ready
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
`ifdef IMEM_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int RAM_W = DATA_WIDTH + PAR_W;

    imem_state_e           r_state;
    imem_state_e           w_state_next;
    logic [ADDR_WIDTH-1:0] r_clr_cnt;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_waddr;
    logic [DATA_WIDTH-1:0] w_wdata_raw;
    logic [RAM_W-1:0]      w_wdata;
    logic [ADDR_WIDTH-1:0] w_index;
    logic                  w_fault;
    logic                  w_accept;
    logic                  w_re;
    logic [RAM_W-1:0]      w_rdata;
    logic                  w_par_bad;
    logic                  r_valid;
    logic                  r_fault;

    // Sequencer state and the clear counter. Reset always restarts CLEAR,
    // which also aborts any load or fetch that was in progress.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == CLEAR) begin
                r_clr_cnt <= r_clr_cnt + 1'b1;
            end
        end
    end

    // Next state and write-port steering. CLEAR owns the write port for
    // DEPTH cycles; LOAD hands it to the load port; RUN never writes, so
    // stray load_we strobes are harmless.
    always_comb begin
        w_state_next = r_state;
        w_we         = 1'b0;
        w_waddr      = i_load_addr;
        w_wdata_raw  = i_load_data;
        case (r_state)
            CLEAR: begin
                w_we        = 1'b1;
                w_waddr     = r_clr_cnt;
                w_wdata_raw = DATA_WIDTH'(NOP_WORD);
                if (r_clr_cnt == ADDR_WIDTH'(DEPTH - 1)) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (i_load_start) begin
                    w_state_next = LOAD;
                end
            end
            LOAD: begin
                w_we = i_load_we;
                if (i_load_done) begin
                    w_state_next = RUN;
                end
            end
            default: w_state_next = CLEAR;
        endcase
    end

    // Address decode and acceptance. A flush drops a same-cycle request, and
    // a faulted fetch leaves the array unread so o_instr can show NOP_WORD.
    always_comb begin
        w_index = '0;
        if (BYTE_ADDR != 0) begin
            w_index = i_fetch_pc[ADDR_WIDTH+1:2];
        end else begin
            w_index = i_fetch_pc[ADDR_WIDTH-1:0];
        end
        w_fault  = fetch_fault_check(i_fetch_pc, ADDR_WIDTH, BYTE_ADDR != 0);
        w_accept = (r_state == RUN) && i_fetch_req && !i_fetch_stall && !i_fetch_flush;
        w_re     = w_accept && !w_fault;
    end

`ifdef IMEM_PARITY_EN
    // Stored bit makes each word even parity, so any single-bit upset turns
    // the XOR over the whole stored word to 1.
    assign w_wdata   = {^w_wdata_raw, w_wdata_raw};
    assign w_par_bad = ^w_rdata;
`else
    assign w_wdata   = w_wdata_raw;
    assign w_par_bad = 1'b0;
`endif

    imem_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .WIDTH      (RAM_W)
    ) u_ram (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_re    (w_re),
        .i_raddr (w_index),
        .o_rdata (w_rdata)
    );

    // Valid/fault output registers. Flush beats stall; stall freezes both
    // registers (and, via w_re, the RAM read register) so every fetch output
    // holds.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_fault <= 1'b0;
        end else if (i_fetch_flush) begin
            r_valid <= 1'b0;
            r_fault <= 1'b0;
        end else if (!i_fetch_stall) begin
            r_valid <= w_accept;
            r_fault <= w_accept && w_fault;
        end
    end

    assign o_instr       = r_fault ? DATA_WIDTH'(NOP_WORD) : w_rdata[DATA_WIDTH-1:0];
    assign o_instr_valid = r_valid;
    assign o_fetch_fault = r_fault;
    assign o_parity_err  = r_valid && !r_fault && w_par_bad;
    assign o_ready       = (r_state == RUN);

endmodule

// File: tb/tb_imem_fetch.sv
// ---------------------------------------------------------------------------
// tb_imem_fetch
// Self-checking bench for imem_fetch (default parameters: 64 words, byte
// addressed). Expected fetch results are pushed to a scoreboard queue when a
// request is driven and popped when the output appears one cycle later.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Honours IMEM_PARITY_EN for the parity scenario.
// ---------------------------------------------------------------------------
module tb_imem_fetch;

    typedef struct packed {
        logic        valid;
        logic        fault;
        logic        perr;
        logic [31:0] instr;
    } exp_t;

    typedef struct packed {
        logic        req;
        logic [31:0] pc;
        logic        stall;
        logic        flush;
        exp_t        exp;
        exp_t        mask;
    } step_t;

    localparam exp_t MASK_ALL   = '1;
    localparam exp_t MASK_VALID = {1'b1, 1'b0, 1'b0, 32'h0};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_req;
    logic [31:0] fetch_pc;
    logic        fetch_stall;
    logic        fetch_flush;
    logic [31:0] instr;
    logic        instr_valid;
    logic        fetch_fault;
    logic        parity_err;
    logic        load_start;
    logic        load_done;
    logic        load_we;
    logic [5:0]  load_addr;
    logic [31:0] load_data;
    logic        ready;

    exp_t obs;
    exp_t scoreboard[$];
    exp_t mask_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    assign obs = {instr_valid, fetch_fault, parity_err, instr};

    always #5 clk = ~clk;

    imem_fetch dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_fetch_req   (fetch_req),
        .i_fetch_pc    (fetch_pc),
        .i_fetch_stall (fetch_stall),
        .i_fetch_flush (fetch_flush),
        .o_instr       (instr),
        .o_instr_valid (instr_valid),
        .o_fetch_fault (fetch_fault),
        .o_parity_err  (parity_err),
        .i_load_start  (load_start),
        .i_load_done   (load_done),
        .i_load_we     (load_we),
        .i_load_addr   (load_addr),
        .i_load_data   (load_data),
        .o_ready       (ready)
    );

    function automatic exp_t mk(input logic v, input logic f, input logic p, input logic [31:0] d);
        mk = {v, f, p, d};
    endfunction

    function automatic step_t st(input logic req, input logic [31:0] pc, input logic stall,
                                 input logic flush, input exp_t e, input exp_t m);
        st = {req, pc, stall, flush, e, m};
    endfunction

    // Stimulus only: enter LOAD, write one word together with load_done,
    // and come back to RUN. Starts and ends on a falling edge.
    task automatic load_word(input logic [5:0] addr, input logic [31:0] data);
        load_start = 1'b1;
        @(posedge clk); @(negedge clk);
        load_start = 1'b0;
        load_we    = 1'b1;
        load_addr  = addr;
        load_data  = data;
        load_done  = 1'b1;
        @(posedge clk); @(negedge clk);
        load_we    = 1'b0;
        load_done  = 1'b0;
    endtask

    // Reset values, clear-sequence length, first fetch of a cleared word.
    task automatic test_reset();
        step_t steps[$];
        exp_t  e;
        exp_t  m;
        int    cyc;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (obs !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got %h expected %h", obs, 35'h0);
        end
        n_checks++;
        if (ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_ready: got %b expected 0", ready);
        end
        rst_n = 1'b1;
        cyc   = 1;
        while (ready !== 1'b1 && cyc < 200) begin
            @(posedge clk); @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (cyc != 65) begin
            n_fail++;
            $display("[TB] FAIL clear_length: ready rose on cycle %0d expected 65", cyc);
        end
        steps.push_back(st(1'b1, 32'h10, 1'b0, 1'b0, mk(1'b1, 1'b0, 1'b0, 32'h0), MASK_ALL));
        foreach (steps[i]) begin
            fetch_req   = steps[i].req;
            fetch_pc    = steps[i].pc;
            fetch_stall = steps[i].stall;
            fetch_flush = steps[i].flush;
            scoreboard.push_back(steps[i].exp);
            mask_q.push_back(steps[i].mask);
            @(posedge clk); @(negedge clk);
            e = scoreboard.pop_front();
            m = mask_q.pop_front();
            n_checks++;
            if ((obs & m) !== (e & m)) begin
                n_fail++;
                $display("[TB] FAIL reset_fetch[%0d]: got %h expected %h", i, obs & m, e & m);
            end
        end
        fetch_req = 1'b0;
    endtask

    // Load port, refusal of fetches in LOAD, write-then-read ordering,
    // and load_we being ignored in RUN.
    task automatic test_load_fetch();
        step_t steps[$];
        exp_t  e;
        exp_t  m;
        load_start = 1'b1;
        @(posedge clk); @(negedge clk);
        load_start = 1'b0;
        n_checks++;
        if (ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL ready_in_load: got %b expected 0", ready);
        end
        load_we   = 1'b1;
        load_addr = 6'd3;
        load_data = 32'h8C22_0004;
        fetch_req = 1'b1;
        fetch_pc  = 32'h0C;
        @(posedge clk); @(negedge clk);
        n_checks++;
        if (instr_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL fetch_in_load: valid got %b expected 0", instr_valid);
        end
        fetch_req = 1'b0;
        load_addr = 6'd7;
        load_data = 32'hDEAD_BEEF;
        load_done = 1'b1;
        @(posedge clk); @(negedge clk);
        load_done = 1'b0;
        n_checks++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL ready_after_done: got %b expected 1", ready);
        end
        // Strobes in RUN must not overwrite word 3.
        load_addr = 6'd3;
        load_data = 32'hFFFF_FFFF;
        steps.push_back(st(1'b1, 32'h1C, 1'b0, 1'b0, mk(1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF), MASK_ALL));
        steps.push_back(st(1'b1, 32'h0C, 1'b0, 1'b0, mk(1'b1, 1'b0, 1'b0, 32'h8C22_0004), MASK_ALL));
        foreach (steps[i]) begin
            fetch_req   = steps[i].req;
            fetch_pc    = steps[i].pc;
            fetch_stall = steps[i].stall;
            fetch_flush = steps[i].flush;
            scoreboard.push_back(steps[i].exp);
            mask_q.push_back(steps[i].mask);
            @(posedge clk); @(negedge clk);
            e = scoreboard.pop_front();
            m = mask_q.pop_front();
            n_checks++;
            if ((obs & m) !== (e & m)) begin
                n_fail++;
                $display("[TB] FAIL load_fetch[%0d]: got %h expected %h", i, obs & m, e & m);
            end
        end
        fetch_req = 1'b0;
        load_we   = 1'b0;
    endtask

    // Misaligned and out-of-range addresses, plus the last valid word.
    task automatic test_faults();
        step_t steps[$];
        exp_t  e;
        exp_t  m;
        steps.push_back(st(1'b1, 32'h0E,  1'b0, 1'b0, mk(1'b1, 1'b1, 1'b0, 32'h0), MASK_ALL));
        steps.push_back(st(1'b1, 32'h100, 1'b0, 1'b0, mk(1'b1, 1'b1, 1'b0, 32'h0), MASK_ALL));
        steps.push_back(st(1'b1, 32'h0C,  1'b0, 1'b0, mk(1'b1, 1'b0, 1'b0, 32'h8C22_0004), MASK_ALL));
        steps.push_back(st(1'b1, 32'hFC,  1'b0, 1'b0, mk(1'b1, 1'b0, 1'b0, 32'h0), MASK_ALL));
        steps.push_back(st(1'b1, 32'h02,  1'b0, 1'b0, mk(1'b1, 1'b1, 1'b0, 32'h0), MASK_ALL));
        foreach (steps[i]) begin
            fetch_req   = steps[i].req;
            fetch_pc    = steps[i].pc;
            fetch_stall = steps[i].stall;
            fetch_flush = steps[i].flush;
            scoreboard.push_back(steps[i].exp);
            mask_q.push_back(steps[i].mask);
            @(posedge clk); @(negedge clk);
            e = scoreboard.pop_front();
            m = mask_q.pop_front();
            n_checks++;
            if ((obs & m) !== (e & m)) begin
                n_fail++;
                $display("[TB] FAIL faults[%0d]: got %h expected %h", i, obs & m, e & m);
            end
        end
        fetch_req = 1'b0;
    endtask

    // Back-to-back fetches with a 3-cycle stall, then flush against a
    // request and against a stall.
    task automatic test_stall_flush();
        step_t steps[$];
        exp_t  e;
        exp_t  m;
        load_word(6'd0, 32'h1111_0000);
        load_word(6'd1, 32'h2222_0001);
        steps.push_back(st(1'b1, 32'h0, 1'b0, 1'b0, mk(1'b1, 1'b0, 1'b0, 32'h1111_0000), MASK_ALL));
        steps.push_back(st(1'b1, 32'h4, 1'b1, 1'b0, mk(1'b1, 1'b0, 1'b0, 32'h1111_0000), MASK_ALL));
        steps.push_back(st(1'b1, 32'h4, 1'b1, 1'b0, mk(1'b1, 1'b0, 1'b0, 32'h1111_0000), MASK_ALL));
        steps.push_back(st(1'b1, 32'h4, 1'b1, 1'b0, mk(1'b1, 1'b0, 1'b0, 32'h1111_0000), MASK_ALL));
        steps.push_back(st(1'b1, 32'h4, 1'b0, 1'b0, mk(1'b1, 1'b0, 1'b0, 32'h2222_0001), MASK_ALL));
        steps.push_back(st(1'b1, 32'h0, 1'b0, 1'b1, mk(1'b0, 1'b0, 1'b0, 32'h0), MASK_VALID));
        steps.push_back(st(1'b0, 32'h0, 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, 32'h0), MASK_VALID));
        steps.push_back(st(1'b1, 32'h4, 1'b0, 1'b0, mk(1'b1, 1'b0, 1'b0, 32'h2222_0001), MASK_ALL));
        steps.push_back(st(1'b1, 32'h0, 1'b1, 1'b1, mk(1'b0, 1'b0, 1'b0, 32'h0), MASK_VALID));
        steps.push_back(st(1'b1, 32'h0, 1'b1, 1'b0, mk(1'b0, 1'b0, 1'b0, 32'h0), MASK_VALID));
        steps.push_back(st(1'b1, 32'h0, 1'b0, 1'b0, mk(1'b1, 1'b0, 1'b0, 32'h1111_0000), MASK_ALL));
        foreach (steps[i]) begin
            fetch_req   = steps[i].req;
            fetch_pc    = steps[i].pc;
            fetch_stall = steps[i].stall;
            fetch_flush = steps[i].flush;
            scoreboard.push_back(steps[i].exp);
            mask_q.push_back(steps[i].mask);
            @(posedge clk); @(negedge clk);
            e = scoreboard.pop_front();
            m = mask_q.pop_front();
            n_checks++;
            if ((obs & m) !== (e & m)) begin
                n_fail++;
                $display("[TB] FAIL stall_flush[%0d]: got %h expected %h", i, obs & m, e & m);
            end
        end
        fetch_req   = 1'b0;
        fetch_stall = 1'b0;
        fetch_flush = 1'b0;
    endtask

    // Parity reporting: with the feature on, word 5 gets a flipped data bit
    // behind the sequencer's back; without it parity_err must stay low.
    task automatic test_parity();
        step_t steps[$];
        exp_t  e;
        exp_t  m;
        load_word(6'd5, 32'hA5A5_0001);
`ifdef IMEM_PARITY_EN
        dut.u_ram.r_mem[5] = dut.u_ram.r_mem[5] ^ 33'h1;
        steps.push_back(st(1'b1, 32'h14, 1'b0, 1'b0, mk(1'b1, 1'b0, 1'b1, 32'hA5A5_0000), MASK_ALL));
`else
        steps.push_back(st(1'b1, 32'h14, 1'b0, 1'b0, mk(1'b1, 1'b0, 1'b0, 32'hA5A5_0001), MASK_ALL));
`endif
        steps.push_back(st(1'b1, 32'h15, 1'b0, 1'b0, mk(1'b1, 1'b1, 1'b0, 32'h0), MASK_ALL));
        steps.push_back(st(1'b1, 32'h18, 1'b0, 1'b0, mk(1'b1, 1'b0, 1'b0, 32'h0), MASK_ALL));
        foreach (steps[i]) begin
            fetch_req   = steps[i].req;
            fetch_pc    = steps[i].pc;
            fetch_stall = steps[i].stall;
            fetch_flush = steps[i].flush;
            scoreboard.push_back(steps[i].exp);
            mask_q.push_back(steps[i].mask);
            @(posedge clk); @(negedge clk);
            e = scoreboard.pop_front();
            m = mask_q.pop_front();
            n_checks++;
            if ((obs & m) !== (e & m)) begin
                n_fail++;
                $display("[TB] FAIL parity[%0d]: got %h expected %h", i, obs & m, e & m);
            end
        end
        fetch_req = 1'b0;
    endtask

    // Reset in the middle of LOAD: outputs return to reset values, the full
    // clear runs again and previously loaded words read back as NOP.
    task automatic test_reset_abort();
        step_t steps[$];
        exp_t  e;
        exp_t  m;
        int    cyc;
        fetch_req = 1'b1;
        fetch_pc  = 32'h0C;
        @(posedge clk); @(negedge clk);
        fetch_req  = 1'b0;
        load_start = 1'b1;
        @(posedge clk); @(negedge clk);
        load_start = 1'b0;
        load_we    = 1'b1;
        load_addr  = 6'd3;
        load_data  = 32'hCAFE_F00D;
        @(posedge clk); @(negedge clk);
        load_we = 1'b0;
        rst_n   = 1'b0;
        repeat (2) begin
            @(posedge clk); @(negedge clk);
        end
        n_checks++;
        if (obs !== '0 || ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL abort_reset_state: got %h ready %b expected 0 ready 0", obs, ready);
        end
        rst_n = 1'b1;
        cyc   = 1;
        while (ready !== 1'b1 && cyc < 200) begin
            @(posedge clk); @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (cyc != 65) begin
            n_fail++;
            $display("[TB] FAIL abort_clear_length: ready rose on cycle %0d expected 65", cyc);
        end
        steps.push_back(st(1'b1, 32'h0C, 1'b0, 1'b0, mk(1'b1, 1'b0, 1'b0, 32'h0), MASK_ALL));
        steps.push_back(st(1'b1, 32'h1C, 1'b0, 1'b0, mk(1'b1, 1'b0, 1'b0, 32'h0), MASK_ALL));
        steps.push_back(st(1'b1, 32'h00, 1'b0, 1'b0, mk(1'b1, 1'b0, 1'b0, 32'h0), MASK_ALL));
        foreach (steps[i]) begin
            fetch_req   = steps[i].req;
            fetch_pc    = steps[i].pc;
            fetch_stall = steps[i].stall;
            fetch_flush = steps[i].flush;
            scoreboard.push_back(steps[i].exp);
            mask_q.push_back(steps[i].mask);
            @(posedge clk); @(negedge clk);
            e = scoreboard.pop_front();
            m = mask_q.pop_front();
            n_checks++;
            if ((obs & m) !== (e & m)) begin
                n_fail++;
                $display("[TB] FAIL reset_abort[%0d]: got %h expected %h", i, obs & m, e & m);
            end
        end
        fetch_req = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        fetch_req   = 1'b0;
        fetch_pc    = 32'h0;
        fetch_stall = 1'b0;
        fetch_flush = 1'b0;
        load_start  = 1'b0;
        load_done   = 1'b0;
        load_we     = 1'b0;
        load_addr   = 6'd0;
        load_data   = 32'h0;
        @(negedge clk);
        test_reset();
        test_load_fetch();
        test_faults();
        test_stall_flush();
        test_parity();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
